wrap_request_gen: RTL and testbench

//   Initiator side of the enable/req1/req2 counter-wrap protocol. Drives enable to a free-running
//   MS_BIT+1 counter and raises req1 and req2 together for the one clock edge on which that counter

---
 rtl/wrap_req_pkg.sv | 15 +
 rtl/wrap_threshold_cmp.sv | 27 ++
 rtl/wrap_request_gen.sv | 115 +++++++++++
 tb/tb_wrap_request_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wrap_req_pkg.sv
// Shared types and default constants for the counter-wrap request generator.
package wrap_req_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ARM   = 3'd2,
    CHECK = 3'd3,
    FAULT = 3'd4
  } wrap_state_t;

  localparam int DEF_MS_BIT  = 16;
  localparam int DEF_RST_VAL = 1 << 12;

endpackage

// File: rtl/wrap_threshold_cmp.sv
// Combinational threshold decode of the returned counter value.
module wrap_threshold_cmp #(
  parameter int MS_BIT  = 16,
  parameter int RST_VAL = 1 << 12,
  parameter int DNG_VAL = RST_VAL + 1
) (
  input  logic [MS_BIT:0] i_cnt_in,
  output logic            o_at_arm,
  output logic            o_past_arm,
  output logic            o_danger,
  output logic            o_is_wrapped
);

  // Arm point sits two below RST_VAL: one edge to enter ARM, one edge for the wrap itself.
  localparam logic [MS_BIT:0] ARM_V = (MS_BIT+1)'(RST_VAL - 2);
  localparam logic [MS_BIT:0] DNG_V = (MS_BIT+1)'(DNG_VAL);
  localparam logic [MS_BIT:0] ONE_V = (MS_BIT+1)'(1);

  // Unsigned compares at counter width.
  always_comb begin
    o_at_arm     = (i_cnt_in == ARM_V);
    o_past_arm   = (i_cnt_in >  ARM_V);
    o_danger     = (i_cnt_in >= DNG_V);
    o_is_wrapped = (i_cnt_in <= ONE_V);
  end

endmodule

// File: rtl/wrap_request_gen.sv
// Initiator for the enable/req1/req2 counter-wrap protocol with wrap counting and sticky fault.
module wrap_request_gen
  import wrap_req_pkg::*;
#(
  parameter int MS_BIT  = DEF_MS_BIT,
  parameter int RST_VAL = DEF_RST_VAL,
  parameter int DNG_VAL = RST_VAL + 1,
  parameter int WRAP_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [MS_BIT:0]   i_cnt_in,
  output logic              o_enable,
  output logic              o_req1,
  output logic              o_req2,
  output logic              o_busy,
  output logic [WRAP_W-1:0] o_wrap_count,
  output logic              o_fault
);

  wrap_state_t       r_state, w_nxt_state;
  logic              r_stop_pend, w_nxt_pend;
  logic              r_just_wrapped;
  logic              r_enable, r_req, r_busy, r_fault;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              w_inc;
  logic              w_at_arm, w_past_arm, w_danger, w_is_wrapped;

  wrap_threshold_cmp #(
    .MS_BIT  (MS_BIT),
    .RST_VAL (RST_VAL),
    .DNG_VAL (DNG_VAL)
  ) u_cmp (
    .i_cnt_in     (i_cnt_in),
    .o_at_arm     (w_at_arm),
    .o_past_arm   (w_past_arm),
    .o_danger     (w_danger),
    .o_is_wrapped (w_is_wrapped)
  );

  // Next-state decision; fault triggers override every other transition.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pend  = r_stop_pend;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_nxt_state = RUN;
      end
      RUN: begin
        // Right after a wrap the counter may legitimately sit above the arm point (tiny RST_VAL).
        if (w_danger || (w_past_arm && !r_just_wrapped)) begin
          w_nxt_state = FAULT;
        end else if (w_at_arm) begin
          w_nxt_state = ARM;
          if (i_stop) w_nxt_pend = 1'b1;
        end else if (i_stop) begin
          w_nxt_state = IDLE;
        end
      end
      ARM: begin
        if (w_danger) begin
          w_nxt_state = FAULT;
        end else begin
          w_nxt_state = CHECK;
          if (i_stop) w_nxt_pend = 1'b1;
        end
      end
      CHECK: begin
        if (w_danger || !w_is_wrapped) begin
          w_nxt_state = FAULT;
        end else begin
          w_inc       = 1'b1;
          w_nxt_state = (r_stop_pend || i_stop) ? IDLE : RUN;
          w_nxt_pend  = 1'b0;
        end
      end
      FAULT:   w_nxt_state = FAULT;
      default: w_nxt_state = FAULT;
    endcase
  end

  // State and registered outputs, all decoded from the next state so they land together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_stop_pend    <= 1'b0;
      r_just_wrapped <= 1'b0;
      r_enable       <= 1'b0;
      r_req          <= 1'b0;
      r_busy         <= 1'b0;
      r_fault        <= 1'b0;
      r_wrap_count   <= '0;
    end else begin
      r_state        <= w_nxt_state;
      r_stop_pend    <= w_nxt_pend;
      r_just_wrapped <= (r_state == CHECK) && (w_nxt_state == RUN);
      r_enable       <= (w_nxt_state == RUN) || (w_nxt_state == ARM) || (w_nxt_state == CHECK);
      r_busy         <= (w_nxt_state == RUN) || (w_nxt_state == ARM) || (w_nxt_state == CHECK);
      r_req          <= (w_nxt_state == ARM);
      r_fault        <= (w_nxt_state == FAULT);
      if (w_inc) r_wrap_count <= r_wrap_count + WRAP_W'(1);
    end
  end

  assign o_enable     = r_enable;
  assign o_req1       = r_req;
  assign o_req2       = r_req;
  assign o_busy       = r_busy;
  assign o_fault      = r_fault;
  assign o_wrap_count = r_wrap_count;

endmodule

// File: tb/tb_wrap_request_gen.sv
// Directed bench for wrap_request_gen with a protocol-following counter model (RST_VAL=16, MS_BIT=7).
module tb_wrap_request_gen;

  localparam int MS_BIT  = 7;
  localparam int RST_VAL = 16;
  localparam int WRAP_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [MS_BIT:0]   cnt = '0;
  logic              enable, req1, req2, busy, fault;
  logic [WRAP_W-1:0] wrap_count;
  logic              m_honor = 1'b1;
  logic [MS_BIT:0]   max_cnt = '0;

  int n_chk = 0;
  int n_err = 0;

  wrap_request_gen #(
    .MS_BIT  (MS_BIT),
    .RST_VAL (RST_VAL),
    .DNG_VAL (RST_VAL + 1),
    .WRAP_W  (WRAP_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_cnt_in     (cnt),
    .o_enable     (enable),
    .o_req1       (req1),
    .o_req2       (req2),
    .o_busy       (busy),
    .o_wrap_count (wrap_count),
    .o_fault      (fault)
  );

  always #5 clk = ~clk;

  // Counter model: increments when enabled, wraps to 0 when both reqs are up (unless disabled).
  always @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (enable) cnt <= (req1 && req2 && m_honor) ? '0 : cnt + 1'b1;
  end

  always @(negedge clk) if (cnt > max_cnt) max_cnt = cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req1 && n < 100) begin tick(); n++; end
    if (!req1) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int seen;
    logic [WRAP_W-1:0] wc0;

    // 1: reset state, start, first wrap
    tick();
    tick();
    chk("rst_enable", enable, 0);
    chk("rst_req",    {req1, req2}, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_fault",  fault, 0);
    chk("rst_wrap",   wrap_count, 0);
    rst = 1'b0;
    pulse_start();
    chk("t1_enable", enable, 1);
    chk("t1_busy",   busy, 1);
    wait_req("t1_req");
    chk("t1_req_cnt", cnt, 15);
    chk("t1_req2",    req2, 1);
    tick();
    chk("t1_wrap_cnt", cnt, 0);
    chk("t1_req_off",  req1, 0);
    tick();
    chk("t1_wrapcnt", wrap_count, 1);
    chk("t1_nofault", fault, 0);

    // 2: 300 wraps from a clean start
    do_reset();
    max_cnt = '0;
    pulse_start();
    for (int w = 0; w < 300; w++) begin
      wait_req("t2_req");
      tick();
    end
    tick();
    chk("t2_wrapcnt", wrap_count, 44);
    chk("t2_maxcnt",  max_cnt <= 8'd16, 1);
    chk("t2_nofault", fault, 0);

    // 3: stop at the arm point defers until the wrap completes
    do_reset();
    pulse_start();
    seen = 0;
    while (cnt != 14 && seen < 100) begin tick(); seen++; end
    chk("t3_at14", cnt, 14);
    wc0 = wrap_count;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_arm_req", req1, 1);
    tick();
    chk("t3_check_en", enable, 1);
    tick();
    chk("t3_idle_en",  enable, 0);
    chk("t3_idle_bsy", busy, 0);
    chk("t3_idle_cnt", cnt <= 8'd1, 1);
    chk("t3_wrapinc",  wrap_count, 32'(wc0) + 1);
    tick();
    chk("t3_held_cnt", cnt, 1);

    // 4: counter ignores req -> fault, counter stops
    do_reset();
    m_honor = 1'b0;
    pulse_start();
    seen = 0;
    while (!fault && seen < 100) begin tick(); seen++; end
    chk("t4_fault",   fault, 1);
    chk("t4_cnt",     cnt, 17);
    chk("t4_enable",  enable, 0);
    chk("t4_busy",    busy, 0);
    tick();
    chk("t4_sticky",  fault, 1);
    chk("t4_stopped", cnt, 17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_clr", fault, 0);
    m_honor = 1'b1;

    // 5: reset in ARM, then a clean resume
    do_reset();
    pulse_start();
    wait_req("t5_req");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req",    {req1, req2}, 0);
    chk("t5_enable", enable, 0);
    pulse_start();
    seen = 0;
    while (wrap_count != 1 && seen < 100) begin tick(); seen++; end
    chk("t5_resume_wrap", wrap_count, 1);
    chk("t5_nofault",     fault, 0);

    // 6: stop alone in IDLE is ignored; start with stop wins
    do_reset();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stop_en",   enable, 0);
    chk("t6_stop_bsy",  busy, 0);
    chk("t6_stop_req",  req1, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t6_both_en",  enable, 1);
    chk("t6_both_bsy", busy, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Invariants checked on every sample point.
  always @(negedge clk) begin
    if (req1 !== req2)        chk("inv_req_eq", req2, req1);
    if (req1 && !enable)      chk("inv_req_en", enable, 1);
    if (fault && enable)      chk("inv_fault_en", enable, 0);
  end

endmodule
